// File: rtl/trng_debiaser.sv
// trng_debiaser: multi-mode debiasing post-processor for a raw TRNG bit stream.
// Modes: bypass, Von Neumann, XOR-pair. It collects min(maxbits, NBITS) output
// bits into y, shifting right with each new bit entering at the MSB. A sticky
// repetition-count health test runs on the raw bits.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   start_p          single-cycle start pulse (accepted in IDLE and ERR)
//   mode[1:0]        00 bypass, 01/11 Von Neumann, 10 XOR-pair
//   din, din_vld     raw bit and its qualifier
//   maxbits[CNTW]    requested output length (clamped to NBITS)
//   busy, done_p     collecting / one-cycle completion pulse
//   rct_err          sticky repetition-count failure
//   bit_cnt[CNTW]    output bits accepted in the current run
//   y[NBITS]         output word
module trng_debiaser #(
    parameter int unsigned NBITS     = 2048,
    parameter int unsigned CNTW      = 12,
    parameter int unsigned RCT_LIMIT = 32,
    parameter int unsigned RCTW      = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_p,
    input  logic [1:0]       mode,
    input  logic             din,
    input  logic             din_vld,
    input  logic [CNTW-1:0]  maxbits,
    output logic             busy,
    output logic             done_p,
    output logic             rct_err,
    output logic [CNTW-1:0]  bit_cnt,
    output logic [NBITS-1:0] y
);

    localparam logic [CNTW-1:0] LP_NMAX  = CNTW'(NBITS);
    localparam logic [RCTW-1:0] LP_RCT   = RCTW'(RCT_LIMIT);
    localparam logic [RCTW-1:0] LP_RUN1  = RCTW'(1);
    localparam logic [CNTW-1:0] LP_CNT1  = CNTW'(1);
    localparam logic [1:0]      MODE_BYP = 2'b00;
    localparam logic [1:0]      MODE_XOR = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10,
        S_ERR  = 2'b11
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [1:0]        r_mode;
    logic [CNTW-1:0]   r_target;
    logic              r_phase;     // 1 when the next valid bit is the second of a pair
    logic              r_last;      // previous raw bit: pair element 'a' and RCT reference
    logic [RCTW-1:0]   r_run;       // 0 means no raw bit seen yet in this run
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic [CNTW-1:0]   r_cnt;
    logic [NBITS-1:0]  r_y;

    logic              w_start;
    logic              w_take;
    logic              w_acc;
    logic              w_bit;
    logic              w_hit;
    logic              w_full;
    logic [RCTW-1:0]   w_run_nxt;
    logic [CNTW-1:0]   w_target_in;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state and per-bit decisions
    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_take      = 1'b0;
        w_acc       = 1'b0;
        w_bit       = 1'b0;
        w_run_nxt   = r_run;
        w_target_in = (maxbits > LP_NMAX) ? LP_NMAX : maxbits;

        // Run counter restarts on the first bit or a change, saturates at the limit
        if ((r_run == '0) || (din != r_last)) w_run_nxt = LP_RUN1;
        else if (r_run != LP_RCT)             w_run_nxt = r_run + LP_RUN1;
        w_hit = (w_run_nxt == LP_RCT);

        case (r_mode)
            MODE_BYP: begin
                w_acc = 1'b1;
                w_bit = din;
            end
            MODE_XOR: begin
                w_acc = r_phase;
                w_bit = r_last ^ din;
            end
            default: begin
                w_acc = r_phase && (r_last != din);
                w_bit = r_last;
            end
        endcase
        w_full = w_acc && ((r_cnt + LP_CNT1) == r_target);

        case (r_state)
            S_IDLE, S_ERR: begin
                if (start_p) begin
                    w_start     = 1'b1;
                    w_state_nxt = (w_target_in == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (din_vld) begin
                    w_take = 1'b1;
                    if (w_hit)       w_state_nxt = S_ERR;
                    else if (w_full) w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath: configuration latch, pair/run tracking, output shift register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode   <= MODE_BYP;
            r_target <= '0;
            r_phase  <= 1'b0;
            r_last   <= 1'b0;
            r_run    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_cnt    <= '0;
            r_y      <= '0;
        end else begin
            r_busy <= (w_state_nxt == S_RUN);
            r_done <= (w_state_nxt == S_DONE);
            if (w_start) begin
                r_mode   <= mode;
                r_target <= w_target_in;
                r_phase  <= 1'b0;
                r_run    <= '0;
                r_err    <= 1'b0;
                r_cnt    <= '0;
                r_y      <= '0;
            end else if (w_take) begin
                r_run  <= w_run_nxt;
                r_last <= din;
                if (r_mode != MODE_BYP) r_phase <= ~r_phase;
                if (w_acc) begin
                    r_y   <= {w_bit, r_y[NBITS-1:1]};
                    r_cnt <= r_cnt + LP_CNT1;
                end
                if (w_hit) r_err <= 1'b1;
            end
        end
    end

    assign busy    = r_busy;
    assign done_p  = r_done;
    assign rct_err = r_err;
    assign bit_cnt = r_cnt;
    assign y       = r_y;

endmodule
